// File: rtl/seq_signed_divider.sv
// rtl/seq_signed_divider.sv - sequential signed divider, 2N/N -> N quotient and remainder
// Restoring core on operand magnitudes, one quotient bit per clock, then sign fix-up.
module seq_signed_divider #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2*N-1:0]   dividend,
  input  logic [N-1:0]     divisor,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     quotient,
  output logic [N-1:0]     remainder,
  output logic             overflow,
  output logic             div_by_zero
);
  localparam int ITER = 2 * N;
  localparam int CW = $clog2(ITER);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DZ   = 2'd3;

  localparam logic [N-1:0]   Q_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]   Q_MIN = {1'b1, {(N-1){1'b0}}};
  localparam logic [2*N-1:0] MAG_POS_LIM = {{(N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic [2*N-1:0] MAG_NEG_LIM = MAG_POS_LIM + 1'b1;
  localparam logic [CW-1:0]  LAST = CW'(ITER - 1);

  logic [1:0]     state;
  logic [CW-1:0]  cnt;
  logic [N:0]     rem;
  logic [2*N-1:0] quo;
  logic [N:0]     dsr_mag;
  logic           q_neg;
  logic           r_neg;

  logic [2*N:0]   dvd_mag;
  logic [N:0]     dsr_in_mag;
  logic [N+1:0]   shifted;
  logic [N+1:0]   trial;
  logic           q_ovf;

  // Extra magnitude bit keeps -2^(2N-1) and -2^(N-1) exact.
  assign dvd_mag    = dividend[2*N-1] ? -{dividend[2*N-1], dividend} : {dividend[2*N-1], dividend};
  assign dsr_in_mag = divisor[N-1] ? -{divisor[N-1], divisor} : {divisor[N-1], divisor};

  assign shifted = {rem, quo[2*N-1]};
  assign trial   = shifted - {1'b0, dsr_mag};
  assign q_ovf   = q_neg ? (quo > MAG_NEG_LIM) : (quo > MAG_POS_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      dsr_mag     <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            q_neg       <= dividend[2*N-1] ^ divisor[N-1];
            r_neg       <= dividend[2*N-1];
            dsr_mag     <= dsr_in_mag;
            if (divisor == '0) begin
              // DZ only needs the raw dividend, so park it in the quotient register.
              quo   <= dividend;
              rem   <= '0;
              state <= DZ;
            end else begin
              // Magnitude MSB pre-loads the partial remainder; it is always 0 in range.
              quo   <= dvd_mag[2*N-1:0];
              rem   <= {{N{1'b0}}, dvd_mag[2*N]};
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (!trial[N+1]) begin
            rem <= trial[N:0];
            quo <= {quo[2*N-2:0], 1'b1};
          end else begin
            rem <= shifted[N:0];
            quo <= {quo[2*N-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          overflow  <= q_ovf;
          if (q_ovf) quotient <= q_neg ? Q_MIN : Q_MAX;
          else       quotient <= q_neg ? -quo[N-1:0] : quo[N-1:0];
          remainder <= r_neg ? -rem[N-1:0] : rem[N-1:0];
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          quotient    <= quo[2*N-1] ? Q_MIN : Q_MAX;
          remainder   <= quo[N-1:0];
          div_by_zero <= 1'b1;
          overflow    <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end
endmodule
